// File: rtl/fazyrv_csub.sv
// fazyrv_csub: chunk-serial subtractor, LSB chunk first, with registered eq/lt/ltu flags
module fazyrv_csub #(
  parameter int CHUNKSIZE = 4,
  parameter int XLEN      = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_in,
  input  logic                 start_i,
  input  logic                 vld_i,
  input  logic [CHUNKSIZE-1:0] a_i,
  input  logic [CHUNKSIZE-1:0] b_i,
  output logic [CHUNKSIZE-1:0] y_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 eq_o,
  output logic                 lt_o,
  output logic                 ltu_o
);
  localparam int NCH = XLEN / CHUNKSIZE;
  localparam int CW = NCH > 1 ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic borrow_q, borrow_d, zacc_q, zacc_d, done_q, done_d;
  logic eq_q, eq_d, lt_q, lt_d, ltu_q, ltu_d;
  logic bout, accept, last, zacc_n, a_msb, b_msb;
  logic [CHUNKSIZE-1:0] y;
  always_comb begin
    {bout, y} = {1'b0, a_i} - {1'b0, b_i} - {{CHUNKSIZE{1'b0}}, ~start_i & borrow_q};
    accept = vld_i & (start_i | state_q == RUN);
    last = accept & ((start_i ? '0 : cnt_q) == LAST);
    zacc_n = (start_i | zacc_q) & ~|y;
    a_msb = a_i[CHUNKSIZE-1];
    b_msb = b_i[CHUNKSIZE-1];
    state_d = last ? IDLE : accept ? RUN : state_q;
    cnt_d = last ? '0 : accept ? (start_i ? CW'(1) : cnt_q + CW'(1)) : cnt_q;
    borrow_d = accept ? bout : borrow_q;
    zacc_d = accept ? zacc_n : zacc_q;
    done_d = last;
    eq_d = last ? zacc_n : eq_q;
    // signed compare from the top chunk: differing signs decide directly, else the sign of the difference
    lt_d = last ? (a_msb & ~b_msb) | (~(a_msb ^ b_msb) & y[CHUNKSIZE-1]) : lt_q;
    ltu_d = last ? bout : ltu_q;
  end
  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      zacc_q   <= 1'b1;
      done_q   <= 1'b0;
      eq_q     <= 1'b0;
      lt_q     <= 1'b0;
      ltu_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      zacc_q   <= zacc_d;
      done_q   <= done_d;
      eq_q     <= eq_d;
      lt_q     <= lt_d;
      ltu_q    <= ltu_d;
    end
  end
  assign y_o    = y;
  assign busy_o = state_q == RUN;
  assign done_o = done_q;
  assign eq_o   = eq_q;
  assign lt_o   = lt_q;
  assign ltu_o  = ltu_q;
endmodule

// File: tb/tb_fazyrv_csub.sv
// tb_fazyrv_csub: directed vector bench for the chunk-serial subtractor at CHUNKSIZE 4, 1 and 8
module tb_fazyrv_csub;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic st4 = 0, v4 = 0, busy4, done4, eq4, lt4, ltu4;
  logic [3:0] a4 = '0, b4 = '0, y4;
  logic st1 = 0, v1 = 0, a1 = 0, b1 = 0, y1, busy1, done1, eq1, lt1, ltu1;
  logic st8 = 0, v8 = 0, busy8, done8, eq8, lt8, ltu8;
  logic [7:0] a8 = '0, b8 = '0, y8;
  int checks = 0, errors = 0;
  fazyrv_csub #(.CHUNKSIZE(4), .XLEN(32)) d4 (.clk_i(clk), .rst_in(rst_n), .start_i(st4), .vld_i(v4),
    .a_i(a4), .b_i(b4), .y_o(y4), .busy_o(busy4), .done_o(done4), .eq_o(eq4), .lt_o(lt4), .ltu_o(ltu4));
  fazyrv_csub #(.CHUNKSIZE(1), .XLEN(32)) d1 (.clk_i(clk), .rst_in(rst_n), .start_i(st1), .vld_i(v1),
    .a_i(a1), .b_i(b1), .y_o(y1), .busy_o(busy1), .done_o(done1), .eq_o(eq1), .lt_o(lt1), .ltu_o(ltu1));
  fazyrv_csub #(.CHUNKSIZE(8), .XLEN(32)) d8 (.clk_i(clk), .rst_in(rst_n), .start_i(st8), .vld_i(v8),
    .a_i(a8), .b_i(b8), .y_o(y8), .busy_o(busy8), .done_o(done8), .eq_o(eq8), .lt_o(lt8), .ltu_o(ltu8));
  typedef struct {
    logic [31:0] a, b, d;
    logic eq, lt, ltu;
  } vec_t;
  vec_t vt[7];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic run4(input logic [31:0] a, input logic [31:0] b, input int st_at, input int st_len,
                      output logic [31:0] diff, output int lat, output int early, output logic busy_mid);
    int cyc = 0;
    diff = '0;
    early = 0;
    busy_mid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      for (int s = 0; s < ((i == st_at) ? st_len : 0); s++) begin
        v4 = 0;
        st4 = 0;
        @(posedge clk); #1; cyc++;
        if (done4) early++;
      end
      v4 = 1;
      st4 = (i == 0);
      a4 = a[i*4 +: 4];
      b4 = b[i*4 +: 4];
      #1 diff[i*4 +: 4] = y4;
      @(posedge clk); #1; cyc++;
      if (done4 && i < 7) early++;
      if (i == 3) busy_mid = busy4;
    end
    v4 = 0;
    st4 = 0;
    lat = done4 ? cyc : -1;
  endtask
  task automatic runx(input int cs, input logic [31:0] a, input logic [31:0] b,
                      output logic [31:0] diff, output int lat);
    logic [7:0] ac, bc;
    int cyc = 0;
    diff = '0;
    lat = -1;
    for (int i = 0; i < 32 / cs; i++) begin
      ac = 8'(a >> (i * cs));
      bc = 8'(b >> (i * cs));
      if (cs == 1) begin
        v1 = 1; st1 = (i == 0); a1 = ac[0]; b1 = bc[0];
      end else begin
        v8 = 1; st8 = (i == 0); a8 = ac; b8 = bc;
      end
      #1 diff = diff | ((cs == 1) ? (32'(y1) << i) : (32'(y8) << (i * 8)));
      @(posedge clk); #1; cyc++;
      if (lat < 0 && ((cs == 1) ? done1 : done8)) lat = cyc;
    end
    v1 = 0; st1 = 0; v8 = 0; st8 = 0;
  endtask
  initial begin
    logic [31:0] diff;
    int lat, early, ndone;
    logic bm;
    vt[0] = '{32'd5,        32'd3,        32'h00000002, 1'b0, 1'b0, 1'b0};
    vt[1] = '{32'd0,        32'd1,        32'hFFFFFFFF, 1'b0, 1'b1, 1'b1};
    vt[2] = '{32'h80000000, 32'd1,        32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
    vt[3] = '{32'd1,        32'h80000000, 32'h80000001, 1'b0, 1'b0, 1'b1};
    vt[4] = '{32'h12345678, 32'h12345678, 32'h00000000, 1'b1, 1'b0, 1'b0};
    vt[5] = '{32'h12345679, 32'h12345678, 32'h00000001, 1'b0, 1'b0, 1'b0};
    vt[6] = '{32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, 1'b0, 1'b1, 1'b0};
    #2;
    chk("rst_busy", 32'(busy4), 32'd0);
    chk("rst_done", 32'(done4), 32'd0);
    chk("rst_eq", 32'(eq4), 32'd0);
    chk("rst_lt", 32'(lt4), 32'd0);
    chk("rst_ltu", 32'(ltu4), 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
    a4 = 4'd5; b4 = 4'd3; #1;
    chk("idle_y", 32'(y4), 32'd2);
    v4 = 1;
    @(posedge clk); #1;
    chk("idle_vld_ignored_busy", 32'(busy4), 32'd0);
    v4 = 0;
    @(posedge clk); #1;
    foreach (vt[k]) begin
      run4(vt[k].a, vt[k].b, -1, 0, diff, lat, early, bm);
      chk($sformatf("v%0d_diff", k), diff, vt[k].d);
      chk($sformatf("v%0d_lat", k), 32'(lat), 32'd8);
      chk($sformatf("v%0d_early", k), 32'(early), 32'd0);
      chk($sformatf("v%0d_busy_mid", k), 32'(bm), 32'd1);
      chk($sformatf("v%0d_busy_done", k), 32'(busy4), 32'd0);
      chk($sformatf("v%0d_eq", k), 32'(eq4), 32'(vt[k].eq));
      chk($sformatf("v%0d_lt", k), 32'(lt4), 32'(vt[k].lt));
      chk($sformatf("v%0d_ltu", k), 32'(ltu4), 32'(vt[k].ltu));
    end
    @(posedge clk); #1;
    chk("done_single_cycle", 32'(done4), 32'd0);
    chk("flags_held_eq", 32'(eq4), 32'd0);
    chk("flags_held_lt", 32'(lt4), 32'd1);
    run4(32'd5, 32'd3, 3, 3, diff, lat, early, bm);
    chk("stall_diff", diff, 32'd2);
    chk("stall_lat", 32'(lat), 32'd11);
    chk("stall_early", 32'(early), 32'd0);
    chk("stall_eq", 32'(eq4), 32'd0);
    chk("stall_lt", 32'(lt4), 32'd0);
    chk("stall_ltu", 32'(ltu4), 32'd0);
    for (int i = 0; i < 5; i++) begin
      v4 = 1; st4 = (i == 0); a4 = (i == 0) ? 4'd5 : 4'd0; b4 = (i == 0) ? 4'd3 : 4'd0;
      @(posedge clk); #1;
    end
    chk("restart_flags_untouched", 32'(eq4), 32'd0);
    run4(32'd7, 32'd7, -1, 0, diff, lat, early, bm);
    chk("restart_diff", diff, 32'd0);
    chk("restart_lat", 32'(lat), 32'd8);
    chk("restart_early", 32'(early), 32'd0);
    chk("restart_eq", 32'(eq4), 32'd1);
    for (int i = 0; i < 4; i++) begin
      v4 = 1; st4 = (i == 0); a4 = 4'd0; b4 = (i == 0) ? 4'd1 : 4'd0;
      @(posedge clk); #1;
    end
    v4 = 0; st4 = 0;
    chk("pre_reset_busy", 32'(busy4), 32'd1);
    rst_n = 0; #1;
    chk("mid_rst_busy", 32'(busy4), 32'd0);
    chk("mid_rst_eq", 32'(eq4), 32'd0);
    chk("mid_rst_lt", 32'(lt4), 32'd0);
    chk("mid_rst_ltu", 32'(ltu4), 32'd0);
    chk("mid_rst_done", 32'(done4), 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done4 || busy4) ndone++;
    end
    chk("post_rst_no_done", 32'(ndone), 32'd0);
    runx(1, 32'd1, 32'd2, diff, lat);
    chk("cs1_diff", diff, 32'hFFFFFFFF);
    chk("cs1_lat", 32'(lat), 32'd32);
    chk("cs1_ltu", 32'(ltu1), 32'd1);
    chk("cs1_lt", 32'(lt1), 32'd1);
    chk("cs1_eq", 32'(eq1), 32'd0);
    runx(8, 32'd1, 32'd2, diff, lat);
    chk("cs8_diff", diff, 32'hFFFFFFFF);
    chk("cs8_lat", 32'(lat), 32'd4);
    chk("cs8_ltu", 32'(ltu8), 32'd1);
    chk("cs8_lt", 32'(lt8), 32'd1);
    chk("cs8_eq", 32'(eq8), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fazyrv_csub.md
Name: fazyrv_csub

Overview:
- Chunk-serial subtractor/comparator; the subtracting counterpart of the core's adder path.
- Consumes two XLEN-bit operands CHUNKSIZE bits per cycle, LSB chunk first.
- Emits the difference chunk in the same cycle.
- After the final chunk, provides registered eq/lt/ltu flags for SUB, SLT(U) and branch evaluation.

Parameters:
- CHUNKSIZE, 4, bits processed per cycle; legal values 1, 2, 4, 8.
- XLEN, 32, operand width; must be a multiple of CHUNKSIZE.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_in  input  1  asynchronous active-low reset.
- start_i  input  1  marks the current chunk as chunk 0 of a new operation; honoured only when vld_i=1.
- vld_i  input  1  current chunk is valid; low = stall, no state change.
- a_i  input  CHUNKSIZE  minuend chunk.
- b_i  input  CHUNKSIZE  subtrahend chunk.
- y_o  output  CHUNKSIZE  difference chunk, combinational.
- busy_o  output  1  operation in progress.
- done_o  output  1  single-cycle pulse, one cycle after the last chunk is accepted.
- eq_o  output  1  a == b, registered.
- lt_o  output  1  signed a < b, registered.
- ltu_o  output  1  unsigned a < b, registered.

Behaviour:
- Reset (rst_in=0, async): state IDLE, cnt=0, borrow_q=0, zacc_q=1, busy_o=0, done_o=0, eq_o=0, lt_o=0, ltu_o=0.
- Chunk arithmetic:
  - bin = start_i ? 0 : borrow_q.
  - {bout, y} = {1'b0,a_i} - {1'b0,b_i} - bin, computed at CHUNKSIZE+1 bits.
  - y_o = y at all times, including IDLE; y_o is don't-care when vld_i=0.
- Accept: a chunk is accepted when vld_i=1 and (start_i=1 or state=RUN). In IDLE, vld_i without start_i is ignored.
- On accept:
  - borrow_q <= bout.
  - zacc_q <= (start_i ? 1 : zacc_q) & (y==0).
  - cnt <= start_i ? 1 : cnt+1.
- Last chunk: the accepted chunk with index NCH-1, where NCH = XLEN/CHUNKSIZE. Chunk index = 0 if start_i, else cnt.
- On the last chunk, flags are latched at the clock edge:
  - ltu_o <= bout.
  - eq_o <= zacc_next.
  - lt_o <= (a_msb & ~b_msb) | (~(a_msb ^ b_msb) & y_msb), where the MSBs are bit CHUNKSIZE-1 of the current chunk.
  - done_o <= 1 for exactly one cycle. State returns to IDLE, cnt <= 0.
- NCH=1 (CHUNKSIZE=XLEN is illegal, so unreachable): no special case is required.
- State machine:
  - IDLE --accepted start_i--> RUN.
  - RUN --last chunk--> IDLE.
  - RUN --start_i & vld_i--> RUN (abort and restart at chunk 0; flags are not updated for the aborted operation).
- busy_o = (state==RUN). busy_o is low in the cycle done_o is high.
- Stall: vld_i=0 holds cnt, borrow_q, zacc_q, state and flags. Latency counts accepted chunks only.
- Latency: with no stalls, done_o asserts NCH cycles after the start cycle (start = cycle 0, done_o in cycle NCH).
- Flags are held from done_o until the next last-chunk update. A new start does not clear them.
- Reset mid-operation aborts immediately to reset values. No done_o pulse is produced.
- Back-to-back: start_i may be asserted in the same cycle done_o is high. The new operation proceeds with no bubble.

Test Plan:
- CHUNKSIZE=4, a=5, b=3, no stalls -> y chunks 2,0,0,0,0,0,0,0; done_o in cycle 8; eq=0, lt=0, ltu=0.
- a=0, b=1 -> every y chunk 0xF (diff 0xFFFFFFFF); ltu=1, lt=1, eq=0.
- a=0x80000000, b=1 -> diff 0x7FFFFFFF; lt=1, ltu=0. Then swap operands -> lt=0, ltu=1.
- a=b=0x12345678 -> diff 0, eq=1. Then a=0x12345679, b=0x12345678 -> eq=0 (nonzero chunk in LSB only), other chunks zero.
- Stall: a=5, b=3 with vld_i low for 3 cycles after chunk 2 -> done_o in cycle 11, identical y/flags. Also: restart via start_i at chunk 5 with a=7, b=7 -> done_o 8 cycles after restart, eq=1.
- Reset pulse at chunk 4 -> busy_o=0, all flags 0 immediately, no done_o. Then a new op with CHUNKSIZE=1 and CHUNKSIZE=8 builds, a=1, b=2 -> ltu=1, done_o after 32 and 4 cycles respectively.
